// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtractive GCD datapath: operand entry handshake, subtract
// sequencing from the comparator flags, and start/done to the host. Optional GCD_TIMEOUT_EN.
module gcd_controller #(
    parameter int unsigned MAX_ITER = 65535,
    parameter int unsigned ITER_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic gt,
    input  logic lt,
    input  logic eq,
    output logic ldA,
    output logic ldB,
    output logic sel1,
    output logic sel2,
    output logic sel_in,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0] state_q, state_d;
    logic       timeout;

`ifdef GCD_TIMEOUT_EN
    localparam logic [ITER_W-1:0] MaxCnt = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    // eq has priority, so a run finishing on the last allowed cycle is not an abort
    assign timeout = (state_q == S_CALC) && !eq && (cnt_q == MaxCnt);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_IDLE && start) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == S_CALC && (ldA || ldB)) begin
            cnt_d = cnt_q + ITER_W'(1);
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_ITER, ITER_W};
    assign timeout    = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel1     = 1'b0;
        sel2     = 1'b0;
        sel_in   = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                sel_in   = 1'b1;
                if (in_valid) begin
                    ldA     = 1'b1;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                sel_in   = 1'b1;
                if (in_valid) begin
                    ldB     = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (eq || timeout) begin
                    state_d = S_DONE;
                end else if (gt) begin
                    sel2 = 1'b1;
                    ldA  = 1'b1;
                end else if (lt) begin
                    sel1 = 1'b1;
                    ldB  = 1'b1;
                end else begin
                    // no flag set cannot come from a sane comparator; finish rather than spin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural A/B datapath closes the loop around the FSM.
// Define GCD_TIMEOUT_EN to also exercise the abort path with MAX_ITER = 8.
module tb_gcd_controller;

`ifdef GCD_TIMEOUT_EN
    localparam int unsigned TbMax = 8;
`else
    localparam int unsigned TbMax = 65535;
`endif

    logic clk, rst, start, in_valid, in_ready;
    logic gt, lt, eq, ldA, ldB, sel1, sel2, sel_in, busy, done, err;
    logic [15:0] data_in, a_q, b_q, mux1, mux2, bus;

    gcd_controller #(
        .MAX_ITER(TbMax),
        .ITER_W  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .gt      (gt),
        .lt      (lt),
        .eq      (eq),
        .ldA     (ldA),
        .ldB     (ldB),
        .sel1    (sel1),
        .sel2    (sel2),
        .sel_in  (sel_in),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always_comb begin
        mux1 = sel1 ? b_q : a_q;
        mux2 = sel2 ? b_q : a_q;
        bus  = sel_in ? data_in : (mux1 - mux2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (ldA) a_q <= bus;
            if (ldB) b_q <= bus;
        end
    end

    assign gt = a_q > b_q;
    assign lt = a_q < b_q;
    assign eq = a_q == b_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int g;
        int iters;
    } vec_t;

    vec_t vecs[13];
    int   checks;
    int   errors;
    int   trace_a[$];
    int   trace_b[$];
    int   exp_a[4];
    int   exp_b[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        step();
        start = 1'b0;
    endtask

    task automatic load_op(input bit is_a, input int val, input int stall);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b0;
            data_in  = 16'hdead;
            #1;
            chk("stall_in_ready", in_ready, 1);
            chk("stall_no_load", ldA | ldB, 0);
            step();
        end
        in_valid = 1'b1;
        data_in  = val[15:0];
        #1;
        chk("load_in_ready", in_ready, 1);
        chk("load_sel_in", sel_in, 1);
        chk("load_busy", busy, 1);
        if (is_a) begin
            chk("load_ldA", ldA, 1);
            chk("load_ldB_idle", ldB, 0);
        end else begin
            chk("load_ldB", ldB, 1);
            chk("load_ldA_idle", ldA, 0);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic calc(input int exp_res, input bit chk_res, input int exp_iters,
                        input bit exp_err, input bit poke);
        int iters;
        bit prev_load;
        bit seen;
        iters     = 0;
        prev_load = 1'b1;
        seen      = 1'b0;
        trace_a.delete();
        trace_b.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (poke) start = 1'b1;
            in_valid = poke;
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            trace_a.push_back(int'(a_q));
            trace_b.push_back(int'(b_q));
            chk("calc_one_load", ldA & ldB, 0);
            chk("calc_in_ready", in_ready, 0);
            chk("calc_sel_in", sel_in, 0);
            prev_load = ldA | ldB;
            if (prev_load) iters++;
            step();
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("eq_cycle_no_load", prev_load, 0);
            chk("done_busy", busy, 1);
            chk("done_no_load", ldA | ldB, 0);
            if (chk_res) chk("aout", int'(a_q), exp_res);
            chk("iters", iters, exp_iters);
            chk("done_err", err, exp_err);
            step();
            start    = 1'b0;
            in_valid = 1'b0;
            #1;
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("err_hold", err, exp_err);
            if (chk_res) chk("aout_hold", int'(a_q), exp_res);
        end
    endtask

    task automatic chk_trace_48_18();
        chk("trace_len", trace_a.size(), 5);
        if (trace_a.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("trace_a", trace_a[i+1], exp_a[i]);
                chk("trace_b", trace_b[i+1], exp_b[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{48, 18, 6, 4};
        vecs[1]  = '{7, 7, 7, 0};
        vecs[2]  = '{35, 21, 7, 3};
        vecs[3]  = '{9, 6, 3, 2};
        vecs[4]  = '{12, 8, 4, 2};
        vecs[5]  = '{1, 1, 1, 0};
        vecs[6]  = '{100, 75, 25, 3};
        vecs[7]  = '{2, 3, 1, 2};
        vecs[8]  = '{21, 13, 1, 6};
        vecs[9]  = '{9, 1, 1, 8};
        vecs[10] = '{5, 1, 1, 4};
        vecs[11] = '{65535, 65535, 65535, 0};
        vecs[12] = '{18, 48, 6, 4};
        exp_a = '{30, 12, 12, 6};
        exp_b = '{18, 18, 6, 6};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        step();
        step();
        #1;
        chk("rst_ldA", ldA, 0);
        chk("rst_ldB", ldB, 0);
        chk("rst_sel", {29'd0, sel1, sel2, sel_in}, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        step();

        // 48/18 with the per-subtraction A/B trace
        do_start();
        load_op(1'b1, 48, 0);
        load_op(1'b0, 18, 0);
        calc(6, 1'b1, 4, 1'b0, 1'b0);
        chk_trace_48_18();

        for (int i = 0; i < 13; i++) begin
            do_start();
            load_op(1'b1, vecs[i].a, 0);
            load_op(1'b0, vecs[i].b, 0);
            calc(vecs[i].g, 1'b1, vecs[i].iters, 1'b0, 1'b0);
        end

        // operand stalls in both load states
        do_start();
        load_op(1'b1, 35, 3);
        load_op(1'b0, 21, 2);
        calc(7, 1'b1, 3, 1'b0, 1'b0);

        // start and in_valid poked throughout CALC and DONE must change nothing
        do_start();
        load_op(1'b1, 48, 0);
        load_op(1'b0, 18, 0);
        calc(6, 1'b1, 4, 1'b0, 1'b1);
        chk_trace_48_18();
        step();
        #1;
        chk("no_restart_busy", busy, 0);

        // reset mid-CALC
        do_start();
        load_op(1'b1, 100, 0);
        load_op(1'b0, 3, 0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        #1;
        chk("midrst_ld", ldA | ldB, 0);
        chk("midrst_sel", {29'd0, sel1, sel2, sel_in}, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("midrst_no_done", done, 0);
            chk("midrst_idle", busy, 0);
        end
        do_start();
        load_op(1'b1, 9, 0);
        load_op(1'b0, 6, 0);
        calc(3, 1'b1, 2, 1'b0, 1'b0);

`ifdef GCD_TIMEOUT_EN
        // zero operand aborts after exactly MAX_ITER subtractions
        do_start();
        load_op(1'b1, 0, 0);
        load_op(1'b0, 5, 0);
        calc(0, 1'b0, 8, 1'b1, 1'b0);
        step();
        step();
        #1;
        chk("err_held_idle", err, 1);
        do_start();
        #1;
        chk("err_clear_on_start", err, 0);
        load_op(1'b1, 12, 0);
        load_op(1'b0, 8, 0);
        calc(4, 1'b1, 2, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- FSM that sequences the 16-bit subtractive GCD datapath (registers A/B, operand muxes, subtractor, comparator).
- Consumes the datapath comparator flags and drives its load/select controls.
- Provides a start/done handshake to the host and a valid/ready handshake for operand entry on the datapath's data_in bus.
- Sits beside the datapath inside the GCD top level; it is the control end of the datapath's control/status interface.

Parameters:
- MAX_ITER, 65535, maximum subtraction cycles before abort (used only with GCD_TIMEOUT_EN).
- ITER_W, 16, iteration counter width; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  host request; sampled only in IDLE.
- in_valid  input  1  operand present on datapath data_in.
- in_ready  output  1  controller accepting an operand this cycle.
- gt  input  1  comparator flag, A > B.
- lt  input  1  comparator flag, A < B.
- eq  input  1  comparator flag, A == B.
- ldA  output  1  load register A from bus.
- ldB  output  1  load register B from bus.
- sel1  output  1  subtractor minuend mux: 0 = A, 1 = B.
- sel2  output  1  subtractor subtrahend mux: 0 = A, 1 = B.
- sel_in  output  1  bus mux: 0 = subtractor output, 1 = data_in.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result is valid on Aout.
- err  output  1  timeout abort flag (GCD_TIMEOUT_EN only).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- On a clock edge with rst = 1:
  - state goes to IDLE; counter clears.
  - ldA, ldB, sel1, sel2, sel_in, in_ready, busy, done and err are all 0.
  - This applies in any state; an in-flight computation is discarded and no done is issued.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE.
- IDLE:
  - All controls are 0.
  - start = 1 moves to LOAD_A.
- LOAD_A:
  - in_ready = 1 and sel_in = 1.
  - When in_valid = 1: ldA = 1 (combinational on in_valid), then move to LOAD_B.
  - When in_valid = 0: hold state; no load.
- LOAD_B:
  - Same as LOAD_A, but drives ldB; then moves to CALC.
- CALC:
  - sel_in = 0; in_ready = 0. Outputs decode combinationally from the flags, which come from registered A/B.
  - Flag priority is eq > gt > lt.
  - eq: no load; move to DONE.
  - gt (A <= A − B): sel1 = 0, sel2 = 1, ldA = 1; stay in CALC; counter increments.
  - lt (B <= B − A): sel1 = 1, sel2 = 0, ldB = 1; stay in CALC; counter increments.
  - No flag asserted (illegal): treated as eq.
- DONE:
  - done = 1 for exactly one cycle; busy = 1.
  - Moves to IDLE.
  - The result remains on Aout until the next LOAD_A load.
- Latency: one cycle per subtraction. Done follows eq detection by one cycle: the done cycle is the cycle after the CALC cycle that sees eq.
- start outside IDLE is ignored; it is not queued.
- in_valid outside LOAD_A/LOAD_B is ignored; in_ready is 0 there.
- The iteration counter clears on entry to LOAD_A.
- Zero operand with a nonzero partner never reaches eq. Without GCD_TIMEOUT_EN this case hangs in CALC until rst; the host must not supply zero operands.
- At most one of ldA/ldB is asserted in any cycle.

Optional Feature:
- Macro: GCD_TIMEOUT_EN.
- Defined:
  - An ITER_W-bit counter counts CALC subtraction cycles.
  - When the counter equals MAX_ITER and eq = 0: no load that cycle; move to DONE with err set.
  - err goes high with done and stays high until the next accepted start.
  - It clears on rst.
- Undefined:
  - No counter is instantiated.
  - err is tied to 0.
  - CALC exits only on eq.

Test Plan:
1. start, then operands 48 and 18 with in_valid held high.
   - Expect ldA/ldB pulses giving A/B = 30/18, 12/18, 12/6, 6/6 (4 subtraction cycles).
   - Expect done one cycle after the eq cycle, Aout = 6, busy low in the following cycle.
2. Operands 7 and 7.
   - Expect zero subtractions: CALC sees eq in the first cycle, then done with Aout = 7.
   - err = 0.
3. in_valid low for 3 cycles in LOAD_A, then pulsed; then low 2 cycles in LOAD_B.
   - Expect in_ready high throughout both waits and no ldA/ldB while in_valid = 0.
   - Result GCD(35, 21) = 7.
4. With GCD_TIMEOUT_EN, MAX_ITER = 8, operands 0 and 5.
   - Expect exactly 8 ldB cycles, then done = 1 and err = 1.
   - err is held until the next start; the next run with 12 and 8 gives err = 0 and Aout = 4.
5. rst asserted mid-CALC (operands 100, 3).
   - Next edge: all outputs 0, state IDLE, no done pulse.
   - A fresh start with 9 and 6 gives Aout = 3.
6. start pulsed during CALC of 48 and 18.
   - Expect no restart and the sequence from scenario 1 unchanged.
   - start is ignored during the done cycle too.
